led_frame_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 25 ++
 rtl/led_frame_sequencer_if.sv | 28 ++
 rtl/led_seq_counters.sv | 60 ++++++
 rtl/led_frame_sequencer.sv | 154 +++++++++++++++
 tb/tb_led_frame_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED frame sequencer.
// Optional build macro: LED_SEQ_PARITY_EN (even-parity check on the captured word).
package led_seq_pkg;

  localparam int unsigned DEF_WORD_BITS = 32;
  localparam int unsigned DEF_MAX_WORDS = 4096;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FORWARD = 2'd2,
    ST_TEST    = 2'd3
  } led_state_e;

  // Ceiling log2, never below 1 so derived counter widths stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/led_frame_sequencer_if.sv
// Bit-decoder input and PWM/re-encoder output bundle of the LED frame sequencer.
// Optional build macro: LED_SEQ_PARITY_EN adds parity_err.
interface led_frame_sequencer_if #(
  parameter int unsigned WORD_BITS = 32
);
  logic                 in_sync;
  logic                 in_clk;
  logic                 in_bit;
  logic [WORD_BITS-1:0] led_word;
  logic                 led_valid;
  logic                 fwd_strobe;
  logic                 fwd_bit;
  logic                 test_mode;
  logic [1:0]           state;
`ifdef LED_SEQ_PARITY_EN
  logic                 parity_err;

  modport master (output in_sync, in_clk, in_bit,
                  input  led_word, led_valid, fwd_strobe, fwd_bit, test_mode, state, parity_err);
  modport slave  (input  in_sync, in_clk, in_bit,
                  output led_word, led_valid, fwd_strobe, fwd_bit, test_mode, state, parity_err);
`else
  modport master (output in_sync, in_clk, in_bit,
                  input  led_word, led_valid, fwd_strobe, fwd_bit, test_mode, state);
  modport slave  (input  in_sync, in_clk, in_bit,
                  output led_word, led_valid, fwd_strobe, fwd_bit, test_mode, state);
`endif
endinterface

// File: rtl/led_seq_counters.sv
// Bit and word counters for the frame sequencer; flags are registered so the FSM
// sees "this strobe ends the word" and "this is the last allowed word" directly.
module led_seq_counters
  import led_seq_pkg::*;
#(
  parameter int unsigned WORD_BITS = DEF_WORD_BITS,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS,
  parameter int unsigned CW        = clog2(MAX_WORDS)
) (
  input  logic clk,
  input  logic rst,
  input  logic cnt_clr,
  input  logic bit_inc,
  input  logic word_set1,
  input  logic word_inc,
  output logic bit_wrap,
  output logic word_last
);

  localparam int unsigned BW = clog2(WORD_BITS);

  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          bit_wrap_q, bit_wrap_d;
  logic          word_last_q, word_last_d;

  // Word counter saturates at MAX_WORDS-1 and never wraps.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    if (cnt_clr) begin
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else begin
      if (bit_inc) bit_cnt_d = bit_wrap_q ? '0 : bit_cnt_q + BW'(1);
      if (word_set1)                       word_cnt_d = CW'(1);
      else if (word_inc && !word_last_q)   word_cnt_d = word_cnt_q + CW'(1);
    end
    bit_wrap_d  = (bit_cnt_d == BW'(WORD_BITS - 1));
    word_last_d = (word_cnt_d == CW'(MAX_WORDS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      bit_wrap_q  <= 1'b0;
      word_last_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      bit_wrap_q  <= bit_wrap_d;
      word_last_q <= word_last_d;
    end
  end

  assign bit_wrap  = bit_wrap_q;
  assign word_last = word_last_q;

endmodule

// File: rtl/led_frame_sequencer.sv
// Frame sequencer: captures the first word of a frame as this LED's data and forwards the rest.
// Optional build macro: LED_SEQ_PARITY_EN (even-parity check, parity_err pulse).
module led_frame_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned WORD_BITS = DEF_WORD_BITS,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS,
  parameter int unsigned CW        = clog2(MAX_WORDS)
) (
  input logic                  clk,
  input logic                  rst,
  led_frame_sequencer_if.slave bus
);

  led_state_e           state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] led_word_q, led_word_d;
  logic                 led_valid_q, led_valid_d;
  logic                 fwd_strobe_q, fwd_strobe_d;
  logic                 fwd_bit_q, fwd_bit_d;
  logic                 test_mode_q, test_mode_d;
  logic                 parity_err_q, parity_err_d;
  logic [WORD_BITS-1:0] shift_nxt;
  logic                 cnt_clr, bit_inc, word_set1, word_inc;
  logic                 bit_wrap, word_last;

  assign shift_nxt = {shift_q[WORD_BITS-2:0], bus.in_bit};

  led_seq_counters #(
    .WORD_BITS (WORD_BITS),
    .MAX_WORDS (MAX_WORDS),
    .CW        (CW)
  ) u_counters (
    .clk       (clk),
    .rst       (rst),
    .cnt_clr   (cnt_clr),
    .bit_inc   (bit_inc),
    .word_set1 (word_set1),
    .word_inc  (word_inc),
    .bit_wrap  (bit_wrap),
    .word_last (word_last)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    led_word_d   = led_word_q;
    led_valid_d  = 1'b0;
    fwd_strobe_d = 1'b0;
    fwd_bit_d    = fwd_bit_q;
    test_mode_d  = test_mode_q;
    parity_err_d = 1'b0;
    cnt_clr      = 1'b0;
    bit_inc      = 1'b0;
    word_set1    = 1'b0;
    word_inc     = 1'b0;

    // A frame gap aborts everything except test mode; a coincident bit is dropped.
    if (state_q != ST_TEST && !bus.in_sync) begin
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CAPTURE;
          if (bus.in_clk) begin
            shift_d = shift_nxt;
            bit_inc = 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (bus.in_clk) begin
            shift_d = shift_nxt;
            bit_inc = 1'b1;
            if (bit_wrap) begin
              word_set1 = 1'b1;
              state_d   = ST_FORWARD;
`ifdef LED_SEQ_PARITY_EN
              if (^shift_nxt == 1'b0) begin
                led_word_d  = shift_nxt;
                led_valid_d = 1'b1;
              end else begin
                parity_err_d = 1'b1;
              end
`else
              led_word_d  = shift_nxt;
              led_valid_d = 1'b1;
`endif
            end
          end
        end
        ST_FORWARD: begin
          if (bus.in_clk) begin
            fwd_strobe_d = 1'b1;
            fwd_bit_d    = bus.in_bit;
            bit_inc      = 1'b1;
            if (bit_wrap) begin
              if (word_last) begin
                state_d     = ST_TEST;
                test_mode_d = 1'b1;
              end else begin
                word_inc = 1'b1;
              end
            end
          end
        end
        ST_TEST: begin
          if (bus.in_clk) begin
            fwd_strobe_d = 1'b1;
            fwd_bit_d    = bus.in_bit;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      led_word_q   <= '0;
      led_valid_q  <= 1'b0;
      fwd_strobe_q <= 1'b0;
      fwd_bit_q    <= 1'b0;
      test_mode_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      led_word_q   <= led_word_d;
      led_valid_q  <= led_valid_d;
      fwd_strobe_q <= fwd_strobe_d;
      fwd_bit_q    <= fwd_bit_d;
      test_mode_q  <= test_mode_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.led_word   = led_word_q;
  assign bus.led_valid  = led_valid_q;
  assign bus.fwd_strobe = fwd_strobe_q;
  assign bus.fwd_bit    = fwd_bit_q;
  assign bus.test_mode  = test_mode_q;
  assign bus.state      = 2'(state_q);
`ifdef LED_SEQ_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = parity_err_q;
`endif

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Randomized bench for led_frame_sequencer against a frame-level bit-index model.
// Works with and without LED_SEQ_PARITY_EN.
module tb_led_frame_sequencer;

  localparam int unsigned W    = 32;
  localparam int unsigned MAXW = 4;

  logic clk = 1'b0;
  logic rst;

  led_frame_sequencer_if #(.WORD_BITS(W)) bus ();

  led_frame_sequencer #(
    .WORD_BITS (W),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: position of the bit within the frame decides its fate.
  int         m_n;
  bit         m_test;
  logic [W-1:0] m_cap, m_word;
  bit         m_valid, m_strobe, m_fbit, m_perr;
  int         m_state;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit c, input bit b);
    if (r) begin
      m_n = 0; m_test = 0; m_word = '0; m_valid = 0; m_strobe = 0;
      m_fbit = 0; m_perr = 0; m_state = 0;
    end else begin
      m_valid = 0; m_strobe = 0; m_perr = 0;
      if (m_test) begin
        if (c) begin m_strobe = 1; m_fbit = b; end
      end else if (!s) begin
        m_n = 0; m_state = 0;
      end else begin
        if (c) begin
          if (m_n < int'(W)) begin
            m_cap[W-1-m_n] = b;
            if (m_n == int'(W) - 1) begin
`ifdef LED_SEQ_PARITY_EN
              if (^m_cap == 1'b0) begin m_word = m_cap; m_valid = 1; end
              else m_perr = 1;
`else
              m_word = m_cap; m_valid = 1;
`endif
            end
          end else begin
            m_strobe = 1; m_fbit = b;
            if (m_n == int'(MAXW * W) - 1) m_test = 1;
          end
          m_n++;
        end
        m_state = (m_n < int'(W)) ? 1 : 2;
      end
      if (m_test) m_state = 3;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit c, input bit b);
    rst = r; bus.in_sync = s; bus.in_clk = c; bus.in_bit = b;
    @(posedge clk);
    model_step(r, s, c, b);
    #1;
    check_eq("led_valid",  bus.led_valid,  m_valid);
    check_eq("led_word",   bus.led_word,   m_word);
    check_eq("fwd_strobe", bus.fwd_strobe, m_strobe);
    check_eq("fwd_bit",    bus.fwd_bit,    m_fbit);
    check_eq("test_mode",  bus.test_mode,  m_test);
    check_eq("state",      bus.state,      m_state);
`ifdef LED_SEQ_PARITY_EN
    check_eq("parity_err", bus.parity_err, m_perr);
`endif
  endtask

  task automatic send_bit(input bit b);
    repeat ($urandom_range(0, 2)) step(0, 1, 0, 0);
    step(0, 1, 1, b);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b0; bus.in_sync = 1'b0; bus.in_clk = 1'b0; bus.in_bit = 1'b0;
    m_cap = '0;
    model_step(1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    gap(2);

    // First frame: own word then 64 forwarded bits
    send_word(32'hA5C3_0F01);
`ifndef LED_SEQ_PARITY_EN
    check_eq("cap_word_const", bus.led_word, 64'hA5C3_0F01);
`endif
    send_word(W'($urandom));
    send_word(W'($urandom));
    gap(3);

    // Abort after 17 bits, then a clean frame
    for (int i = 0; i < 17; i++) send_bit(1'($urandom_range(0, 1)));
    gap(2);
    send_word(32'h1234_5678);
    send_word(W'($urandom));
    gap(2);

    // Five words: test mode on the 4th, gap ignored, forwarding continues
    for (int k = 0; k < 5; k++) send_word(W'($urandom));
    gap(4);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
    check_eq("test_sticky", bus.test_mode, 1'b1);

    // Mid-frame reset held 3 clocks
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
    gap(1);

    // Parity words
    send_word(32'h0000_0003);
    gap(2);
    send_word(32'h0000_0001);
    send_word(W'($urandom));
    gap(2);

    // Random frames of random length, some reaching test mode
    for (int f = 0; f < 25; f++) begin
      int nb;
      nb = $urandom_range(0, 5 * W + 8);
      for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
      gap($urandom_range(1, 3));
      if (m_test) begin
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        repeat ($urandom_range(1, 3)) step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        gap(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
